bcd_to_binary_decoder: RTL and testbench
========================================

BCD_TO_BINARY_DECODER -- requirements
Module: bcd_to_binary_decoder

Interface
REQ-001 SHALL have one clock, clk, with all state updated on its rising edge.
REQ-002 SHALL have reset rst, asynchronous and active-low: rst=0 forces reset immediately, regardless of clk.
REQ-003 Port list:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- start  input  1  conversion request, sampled only in IDLE.
- BCDinput  input  21  [20]=sign (1=negative), [19:0]=five BCD digits, [19:16] most significant.
- binaryOutput  output  18  two's-complement result, registered.
- done  output  1  one-cycle pulse: binaryOutput/v updated.
- busy  output  1  high while a conversion is in progress.
- v  output  1  invalid/overflow flag, registered with binaryOutput.

Function
REQ-004 SHALL implement FSM states IDLE, CONV, FIN.
REQ-005 IDLE with start=1 at edge T0 SHALL:
- capture BCDinput into an internal register;
- clear the 17-bit accumulator and the digit counter;
- go to CONV.
REQ-006 In CONV, edges T1..T5 SHALL each compute acc = acc*10 + digit, MSD first; acc*10 = (acc<<3)+(acc<<1), 17-bit, no overflow possible (max 99999).
REQ-007 After the fifth digit (edge T5) SHALL go to FIN; edge T6 SHALL update binaryOutput/v, assert done, and return to IDLE.
REQ-008 done SHALL be high for exactly the one cycle following T6; total latency = 6 clocks from start-accepting edge to done.
REQ-009 busy SHALL equal (state != IDLE), so busy=0 while done=1.
REQ-010 start while busy SHALL be ignored; captured BCDinput changes mid-conversion SHALL not affect the result.
REQ-011 start=1 in the cycle done=1 SHALL be accepted, giving back-to-back conversions every 7 cycles.
REQ-012 v=1, binaryOutput=0 SHALL result if any captured digit > 9.
REQ-013 v=1, binaryOutput=0 SHALL result if sign=1 and magnitude > 9999 (the matching encoder's negative range).
REQ-014 Otherwise v=0 SHALL hold:
- sign=0: binaryOutput = {1'b0, acc};
- sign=1: binaryOutput = 18-bit two's-complement negation of acc.
REQ-015 Negative zero (sign=1, magnitude 0) SHALL yield binaryOutput=0, v=0.
REQ-016 binaryOutput and v SHALL hold their values between done pulses.

Reset
REQ-017 rst=0 SHALL force state=IDLE and binaryOutput=0, v=0, done=0, busy=0; accumulator, counter and capture register cleared.
REQ-018 Reset during CONV/FIN SHALL abort the conversion with no done pulse; after release, the first start begins a fresh conversion.

Structure
REQ-019 Shared package SHALL hold:
- BCD_W=21, BIN_W=18, ACC_W=17, NDIG=5, MAX_NEG_MAG=9999;
- the IDLE/CONV/FIN state encoding.
REQ-020 One combinational sub-module, bcd_mul10_add (acc, digit -> acc*10+digit, digit>9 flag), SHALL be used; everything else stays in the top module.

Verification
REQ-021 BCDinput {0, 99999} with start pulse -> done 6 cycles later, binaryOutput=18'h1869F, v=0.
REQ-022 BCDinput {1, 09999} -> binaryOutput=18'h3D8F1 (-9999), v=0; {1, 00000} -> binaryOutput=0, v=0.
REQ-023 BCDinput {1, 10000} -> v=1, binaryOutput=0; {0, 1A345} (digit 0xA) -> v=1, binaryOutput=0.
REQ-024 {0, 12345} start, second start and changed BCDinput at T2 -> single done, binaryOutput=18'h03039; start held continuously -> done pulses every 7 cycles.
REQ-025 rst=0 asserted at T3 of a conversion -> all outputs 0 immediately, no done pulse; next start of {0, 00042} -> binaryOutput=18'h0002A.

Source files
------------

// File: rtl/bcd_to_binary_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_binary_decoder_pkg
// Description : Shared widths, limits, FSM encoding and a digit-select
//               helper for the sign-magnitude BCD to two's-complement
//               decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_to_binary_decoder_pkg;

  // Input word: sign bit plus five packed BCD digits
  localparam int BCD_W = 21;
  // Two's-complement result width
  localparam int BIN_W = 18;
  // Unsigned magnitude accumulator width (99999 < 2**17)
  localparam int ACC_W = 17;
  // Number of BCD digits in the input word
  localparam int NDIG  = 5;
  // Digit counter width, enough to index NDIG digits
  localparam int CNT_W = 3;

  // Largest magnitude the matching encoder can produce for a negative value
  localparam logic [ACC_W-1:0] MAX_NEG_MAG = ACC_W'(9999);
  // Counter value of the final (least significant) digit
  localparam logic [CNT_W-1:0] LAST_DIG    = CNT_W'(NDIG - 1);

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Pick BCD digit idx from the 20-bit digit field, idx 0 = most significant
  function automatic logic [3:0] bcd_digit(input logic [BCD_W-2:0] digits,
                                           input logic [CNT_W-1:0] idx);
    logic [3:0] d;
    case (idx)
      3'd0:    d = digits[19:16];
      3'd1:    d = digits[15:12];
      3'd2:    d = digits[11:8];
      3'd3:    d = digits[7:4];
      default: d = digits[3:0];
    endcase
    return d;
  endfunction

endpackage : bcd_to_binary_decoder_pkg
`default_nettype wire

// File: rtl/bcd_to_binary_decoder_bcd_mul10_add.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mul10_add
// Description : One Horner step of BCD-to-binary conversion:
//               acc_out = acc_in*10 + digit, plus a flag when the digit is
//               not a legal BCD value.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mul10_add
  import bcd_to_binary_decoder_pkg::*;
(
  input  logic [ACC_W-1:0] acc_in,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc_out,
  output logic             digit_bad
);

  logic [ACC_W-1:0] w_digit_ext;

  // Multiply by ten as (x<<3)+(x<<1) and fold in the new digit; legal BCD
  // inputs never exceed 99999 so the result fits without overflow
  always_comb begin
    w_digit_ext = {{(ACC_W-4){1'b0}}, digit};
    acc_out     = (acc_in << 3) + (acc_in << 1) + w_digit_ext;
    digit_bad   = (digit > 4'd9);
  end

endmodule : bcd_mul10_add
`default_nettype wire

// File: rtl/bcd_to_binary_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_binary_decoder
// Description : Sequential sign-magnitude BCD (5 digits) to 18-bit
//               two's-complement converter. One digit per clock, MSD first;
//               result and invalid flag registered with a one-cycle done.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_binary_decoder
  import bcd_to_binary_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BCD_W-1:0] BCDinput,
  output logic [BIN_W-1:0] binaryOutput,
  output logic             done,
  output logic             busy,
  output logic             v
);

  state_t             state_q,  state_d;
  logic [BCD_W-1:0]   bcd_q,    bcd_d;
  logic [ACC_W-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               bad_q,    bad_d;
  logic [BIN_W-1:0]   bin_q,    bin_d;
  logic               v_q,      v_d;
  logic               done_q,   done_d;

  logic [3:0]         w_digit;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_digit_bad;
  logic               w_sign;
  logic               w_invalid;

  // Digit currently being folded into the accumulator
  always_comb begin
    w_digit = bcd_digit(bcd_q[BCD_W-2:0], cnt_q);
  end

  bcd_mul10_add u_mul10_add (
    .acc_in    (acc_q),
    .digit     (w_digit),
    .acc_out   (w_acc_next),
    .digit_bad (w_digit_bad)
  );

  // Final-result classification: any non-BCD digit, or a negative value
  // beyond what the companion encoder can represent, is flagged invalid
  always_comb begin
    w_sign    = bcd_q[BCD_W-1];
    w_invalid = bad_q | (w_sign & (acc_q > MAX_NEG_MAG));
  end

  // Next-state and datapath updates for the IDLE/CONV/FIN controller
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    bin_d   = bin_q;
    v_d     = v_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = BCDinput;
          acc_d   = '0;
          cnt_d   = '0;
          bad_d   = 1'b0;
          state_d = CONV;
        end
      end

      CONV: begin
        acc_d = w_acc_next;
        bad_d = bad_q | w_digit_bad;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DIG) begin
          state_d = FIN;
        end
      end

      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (w_invalid) begin
          bin_d = '0;
          v_d   = 1'b1;
        end else if (w_sign) begin
          // Negating zero yields zero, so negative zero needs no special case
          bin_d = BIN_W'(0) - {1'b0, acc_q};
          v_d   = 1'b0;
        end else begin
          bin_d = {1'b0, acc_q};
          v_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      bin_q   <= '0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      bin_q   <= bin_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  // Output drive; busy follows state directly so it drops as done rises
  always_comb begin
    binaryOutput = bin_q;
    v            = v_q;
    done         = done_q;
    busy         = (state_q != IDLE);
  end

endmodule : bcd_to_binary_decoder
`default_nettype wire

// File: tb/tb_bcd_to_binary_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_to_binary_decoder
// Description : Directed self-checking bench for bcd_to_binary_decoder with
//               an expected-result queue popped on each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_binary_decoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [20:0] BCDinput;
  logic [17:0] binaryOutput;
  logic        done;
  logic        busy;
  logic        v;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  // Expected {binaryOutput, v} per accepted conversion
  logic [18:0] sb_q[$];

  bcd_to_binary_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .BCDinput     (BCDinput),
    .binaryOutput (binaryOutput),
    .done         (done),
    .busy         (busy),
    .v            (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled off the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done (bounded), check latency from T0, pop and compare result
  task automatic wait_and_score(input string tag, input int exp_lat);
    int lat;
    logic [18:0] e;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 19'h7FFFF;
    if (lat == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check({tag, "_out"}, {14'd0, binaryOutput}, {14'd0, e[18:1]});
      check({tag, "_v"}, {31'd0, v}, {31'd0, e[0]});
    end
  endtask

  // Single conversion, then confirm done drops and outputs hold
  task automatic run_conv(input string tag, input logic [20:0] bcd,
                          input logic [17:0] eb, input logic ev);
    sb_q.push_back({eb, ev});
    BCDinput = bcd;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    BCDinput = 21'h0_00000;
    wait_and_score(tag, 6);
    tick();
    tick();
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, {13'd0, binaryOutput, v}, {13'd0, eb, ev});
  endtask

  initial begin
    int base;
    int lat;
    int nseen;
    int t_done[3];
    logic [18:0] e;

    rst      = 1'b0;
    start    = 1'b0;
    BCDinput = '0;
    #12;
    check("reset_out",  {14'd0, binaryOutput}, 32'd0);
    check("reset_v",    {31'd0, v},    32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    run_conv("max_pos",   21'h0_99999, 18'h1869F, 1'b0);
    run_conv("max_neg",   21'h1_09999, 18'h3D8F1, 1'b0);
    run_conv("neg_zero",  21'h1_00000, 18'h00000, 1'b0);
    run_conv("neg_ovf",   21'h1_10000, 18'h00000, 1'b1);
    run_conv("bad_digit", 21'h0_1A345, 18'h00000, 1'b1);
    run_conv("neg_one",   21'h1_00001, 18'h3FFFF, 1'b0);
    run_conv("bad_lsd",   21'h1_0000F, 18'h00000, 1'b1);
    run_conv("pos_zero",  21'h0_00000, 18'h00000, 1'b0);

    // Second start plus new input mid-conversion must be ignored
    base = done_cnt;
    sb_q.push_back({18'h03039, 1'b0});
    BCDinput = 21'h0_12345;
    start    = 1'b1;
    tick();                       // T0
    start    = 1'b0;
    tick();                       // T1
    BCDinput = 21'h0_99999;
    start    = 1'b1;
    tick();                       // T2
    start    = 1'b0;
    lat = 0;
    for (int i = 3; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 19'h7FFFF;
    check("midchg_latency", lat, 6);
    check("midchg_out", {14'd0, binaryOutput}, {14'd0, e[18:1]});
    check("midchg_v", {31'd0, v}, {31'd0, e[0]});
    repeat (10) tick();
    check("midchg_single_done", done_cnt - base, 1);

    // Start held high: back-to-back conversions every 7 cycles
    for (int k = 0; k < 3; k++) sb_q.push_back({18'h03039, 1'b0});
    BCDinput = 21'h0_12345;
    start    = 1'b1;
    tick();                       // T0 accepted
    nseen = 0;
    for (int i = 1; i <= 30 && nseen < 3; i++) begin
      tick();
      if (done === 1'b1) begin
        t_done[nseen] = i;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 19'h7FFFF;
        check("b2b_out", {13'd0, binaryOutput, v}, {13'd0, e});
        nseen++;
        if (nseen == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", nseen, 3);
    if (nseen == 3) begin
      check("b2b_first", t_done[0], 6);
      check("b2b_gap1", t_done[1] - t_done[0], 7);
      check("b2b_gap2", t_done[2] - t_done[1], 7);
    end
    repeat (8) tick();
    check("b2b_no_extra", {31'd0, busy}, 32'd0);

    // Reset at T3 aborts the conversion and clears outputs immediately
    base = done_cnt;
    BCDinput = 21'h0_55555;
    start    = 1'b1;
    tick();                       // T0
    start    = 1'b0;
    tick();                       // T1
    tick();                       // T2
    tick();                       // T3
    #1;
    rst = 1'b0;
    #1;
    check("abort_out",  {14'd0, binaryOutput}, 32'd0);
    check("abort_v",    {31'd0, v},    32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    repeat (10) tick();
    check("abort_no_done", done_cnt - base, 0);
    run_conv("after_abort", 21'h0_00042, 18'h0002A, 1'b0);

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the directed sequence stalls
  initial begin
    #200000;
    $display("FAIL global_timeout observed=stalled expected=finish");
    $fatal(1, "timeout");
  end

endmodule : tb_bcd_to_binary_decoder
`default_nettype wire
